// File: rtl/tree_feature_loader.sv
// tree_feature_loader
// Assembles a byte-serial stream of quantised features into one parallel
// feature vector (feature 0 in the low slot) for the combinational decision
// tree. Double-buffered: fill_buf collects the next frame while frame_data is
// held for the consumer.
//
// Ports
//   clk, rst      single rising-edge clock, asynchronous active-high reset
//   s_data        incoming feature value (FW bits)
//   s_valid       s_data is valid
//   s_last        marks the final feature of a frame
//   s_ready       loader can accept a byte (registered)
//   frame_data    feature i at bits [i*FW +: FW]
//   frame_valid   frame_data holds a complete frame
//   frame_ready   consumer has sampled frame_data
//   frame_err     one-cycle pulse when a frame is discarded (short/long/timeout)
//   fill_count    bytes currently in the fill buffer
//   fsm_state     debug view of the FSM: 0=FILL, 1=HOLD, 2=DROP
//
// Handshakes: a byte transfers on an edge where s_valid && s_ready; a frame
// is consumed on an edge where frame_valid && frame_ready. frame_data only
// changes on a load edge, never while frame_valid && !frame_ready.
//
// Optional build macro TREE_LOADER_TIMEOUT_EN: aborts a partial frame after
// TIMEOUT_CYCLES idle cycles in FILL. Without it partial frames wait forever.

module tree_feature_loader #(
   parameter int NUM_FEATURES   = 18,
   parameter int FW             = 8,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int CW            = $clog2(NUM_FEATURES + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [FW-1:0]              s_data,
   input  logic                       s_valid,
   input  logic                       s_last,
   output logic                       s_ready,
   output logic [NUM_FEATURES*FW-1:0] frame_data,
   output logic                       frame_valid,
   input  logic                       frame_ready,
   output logic                       frame_err,
   output logic [CW-1:0]              fill_count,
   output logic [1:0]                 fsm_state
);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HOLD = 2'd1,
      DROP = 2'd2
   } state_t;

   if (NUM_FEATURES < 2 || NUM_FEATURES > 64 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("tree_feature_loader: parameter out of range");
   end

   state_t                    state;
   logic [NUM_FEATURES*FW-1:0] fill_buf;
   logic [NUM_FEATURES*FW-1:0] merged;
   logic                      xfer;
   logic                      wr_en;
   logic                      last_slot;
   logic                      can_load;
   logic                      timeout_hit;

   assign xfer      = s_valid && s_ready;
   assign wr_en     = xfer && (state == FILL);
   assign last_slot = (fill_count == CW'(NUM_FEATURES - 1));
   assign can_load  = !frame_valid || frame_ready;
   assign fsm_state = state;

   // The final byte is not yet in fill_buf on its own transfer edge, so a
   // same-edge load takes it straight from s_data.
   always_comb begin
      merged = fill_buf;
      merged[(NUM_FEATURES-1)*FW +: FW] = s_data;
   end

`ifdef TREE_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;

   // Fires on the TIMEOUT_CYCLES-th consecutive idle edge of a partial frame.
   assign timeout_hit = (state == FILL) && (fill_count != '0) && !xfer &&
                        (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (state != FILL || xfer || fill_count == '0 || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FILL;
         s_ready     <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         fill_count  <= '0;
         frame_data  <= '0;
         fill_buf    <= '0;
      end else begin
         frame_err <= 1'b0;
         if (frame_valid && frame_ready) frame_valid <= 1'b0;

         for (int i = 0; i < NUM_FEATURES; i++) begin
            if (wr_en && fill_count == CW'(i)) fill_buf[i*FW +: FW] <= s_data;
         end

         case (state)
            FILL: begin
               s_ready <= 1'b1;
               if (xfer) begin
                  if (last_slot && s_last) begin
                     if (can_load) begin
                        frame_data  <= merged;
                        frame_valid <= 1'b1;
                        fill_count  <= '0;
                     end else begin
                        // Output buffer busy: keep the full frame in fill_buf
                        // and stop accepting until the consumer frees it.
                        state   <= HOLD;
                        s_ready <= 1'b0;
                     end
                  end else if (s_last) begin
                     frame_err  <= 1'b1;
                     fill_count <= '0;
                  end else if (last_slot) begin
                     frame_err  <= 1'b1;
                     fill_count <= '0;
                     state      <= DROP;
                  end else begin
                     fill_count <= fill_count + 1'b1;
                  end
               end else if (timeout_hit) begin
                  frame_err  <= 1'b1;
                  fill_count <= '0;
               end
            end
            HOLD: begin
               if (frame_ready) begin
                  frame_data  <= fill_buf;
                  frame_valid <= 1'b1;
                  fill_count  <= '0;
                  state       <= FILL;
                  s_ready     <= 1'b1;
               end
            end
            DROP: begin
               s_ready <= 1'b1;
               if (xfer && s_last) state <= FILL;
            end
            default: begin
               state   <= FILL;
               s_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tree_feature_loader.sv
// Bench for tree_feature_loader: frame-level vector table (good, short, long
// frames) plus hand-written sequences for HOLD back-pressure, asynchronous
// mid-frame reset and the partial-frame idle behaviour.

module tb_tree_feature_loader;

   localparam int N  = 18;
   localparam int FW = 8;
   localparam int DW = N * FW;
   localparam int CW = $clog2(N + 1);
`ifdef TREE_LOADER_TIMEOUT_EN
   localparam int TO = 10;
   localparam int EXP_ERRS = 5;
`else
   localparam int TO = 255;
   localparam int EXP_ERRS = 4;
`endif

   logic          clk;
   logic          rst = 1'b0;
   logic [FW-1:0] s_data;
   logic          s_valid;
   logic          s_last;
   logic          s_ready;
   logic [DW-1:0] frame_data;
   logic          frame_valid;
   logic          frame_ready;
   logic          frame_err;
   logic [CW-1:0] fill_count;
   logic [1:0]    fsm_state;

   int n_checks = 0;
   int n_fail   = 0;
   int err_pulses = 0;
   logic prev_err = 1'b0;

   tree_feature_loader #(
      .NUM_FEATURES(N), .FW(FW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .frame_data(frame_data), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .frame_err(frame_err),
      .fill_count(fill_count), .fsm_state(fsm_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0] base;
      int         len;
      int         err_at;
      bit         good;
      logic [7:0] exp_first;
      logic [7:0] exp_last;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] frame_of(input logic [7:0] base);
      logic [DW-1:0] v;
      for (int i = 0; i < N; i++) v[i*FW +: FW] = base + 8'(i);
      return v;
   endfunction

   // One byte per call; waits (bounded) for s_ready, returns on the negedge
   // after the transfer edge.
   task automatic push(input logic [7:0] d, input logic l);
      int guard;
      guard = 0;
      while (!s_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: s_ready stayed 0 for %0d cycles, required 1", guard);
      end
      s_data  = d;
      s_valid = 1'b1;
      s_last  = l;
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic push_frame(input logic [7:0] base);
      for (int i = 0; i < N; i++) push(base + 8'(i), i == N - 1);
   endtask

   // frame_err pulse counter and width check
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err && !prev_err) err_pulses++;
         if (frame_err && prev_err) begin
            n_checks++;
            n_fail++;
            $display("FAIL err_width: frame_err high 2 cycles, required 1");
         end
      end
      prev_err = frame_err;
   end

   initial begin
      s_data = '0; s_valid = 1'b0; s_last = 1'b0; frame_ready = 1'b1;

      tbl[0] = '{8'h00, 18, -1, 1'b1, 8'h00, 8'h11};
      tbl[1] = '{8'h40,  5,  4, 1'b0, 8'h00, 8'h00};
      tbl[2] = '{8'h80, 18, -1, 1'b1, 8'h80, 8'h91};
      tbl[3] = '{8'hA0, 20, 17, 1'b0, 8'h00, 8'h00};
      tbl[4] = '{8'hC0, 18, -1, 1'b1, 8'hC0, 8'hD1};
      tbl[5] = '{8'h33,  1,  0, 1'b0, 8'h00, 8'h00};
      tbl[6] = '{8'h70, 17, 16, 1'b0, 8'h00, 8'h00};

      // ---------------- reset (asynchronous, no clock edge yet) -------------
      #1 rst = 1'b1;
      #1;
      chk("rst_s_ready", DW'(s_ready), 0);
      chk("rst_frame_valid", DW'(frame_valid), 0);
      chk("rst_frame_err", DW'(frame_err), 0);
      chk("rst_fill_count", DW'(fill_count), 0);
      chk("rst_frame_data", frame_data, '0);
      chk("rst_fsm", DW'(fsm_state), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("rel_s_ready_low", DW'(s_ready), 0);
      @(negedge clk);
      chk("rel_s_ready_high", DW'(s_ready), 1);

      // ---------------- table of frames, consumer always ready --------------
      for (int k = 0; k < 7; k++) begin
         for (int i = 0; i < tbl[k].len; i++) begin
            push(tbl[k].base + 8'(i), i == tbl[k].len - 1);
            chk($sformatf("v%0d_err_b%0d", k, i), DW'(frame_err), DW'(i == tbl[k].err_at));
            chk($sformatf("v%0d_valid_b%0d", k, i), DW'(frame_valid),
                DW'(tbl[k].good && i == tbl[k].len - 1));
         end
         if (tbl[k].good) begin
            chk($sformatf("v%0d_first", k), DW'(frame_data[7:0]), DW'(tbl[k].exp_first));
            chk($sformatf("v%0d_last", k), DW'(frame_data[DW-1 -: 8]), DW'(tbl[k].exp_last));
            chk($sformatf("v%0d_data", k), frame_data, frame_of(tbl[k].base));
         end
         chk($sformatf("v%0d_fill0", k), DW'(fill_count), 0);
         @(negedge clk);
         chk($sformatf("v%0d_valid_drop", k), DW'(frame_valid), 0);
         chk($sformatf("v%0d_fsm_fill", k), DW'(fsm_state), 0);
      end

      // ---------------- back-pressure: second frame waits in HOLD -----------
      frame_ready = 1'b0;
      push_frame(8'h10);
      chk("hold_a_valid", DW'(frame_valid), 1);
      chk("hold_a_data", frame_data, frame_of(8'h10));
      push_frame(8'h30);
      chk("hold_fsm", DW'(fsm_state), 1);
      chk("hold_s_ready", DW'(s_ready), 0);
      chk("hold_a_kept", frame_data, frame_of(8'h10));
      repeat (3) @(negedge clk);
      chk("hold_a_kept_late", frame_data, frame_of(8'h10));
      chk("hold_valid_kept", DW'(frame_valid), 1);
      frame_ready = 1'b1;
      @(negedge clk);
      chk("hold_b_data", frame_data, frame_of(8'h30));
      chk("hold_b_valid", DW'(frame_valid), 1);
      chk("hold_b_s_ready", DW'(s_ready), 1);
      chk("hold_b_fsm", DW'(fsm_state), 0);
      @(negedge clk);
      chk("hold_b_consumed", DW'(frame_valid), 0);

      // ---------------- asynchronous reset mid-frame -------------------------
      frame_ready = 1'b0;
      push_frame(8'h50);
      chk("mid_pre_valid", DW'(frame_valid), 1);
      for (int i = 0; i < 9; i++) push(8'h90 + 8'(i), 1'b0);
      chk("mid_pre_fill", DW'(fill_count), 9);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", DW'(frame_valid), 0);
      chk("mid_rst_data", frame_data, '0);
      chk("mid_rst_fill", DW'(fill_count), 0);
      chk("mid_rst_s_ready", DW'(s_ready), 0);
      chk("mid_rst_err", DW'(frame_err), 0);
      @(negedge clk);
      rst = 1'b0;
      frame_ready = 1'b1;
      push_frame(8'h60);
      chk("mid_after_valid", DW'(frame_valid), 1);
      chk("mid_after_data", frame_data, frame_of(8'h60));
      @(negedge clk);

      // ---------------- partial frame left idle ------------------------------
      for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 1'b0);
      chk("idle_fill4", DW'(fill_count), 4);
`ifdef TREE_LOADER_TIMEOUT_EN
      repeat (TO - 1) @(negedge clk);
      chk("to_no_err_early", DW'(frame_err), 0);
      @(negedge clk);
      chk("to_err", DW'(frame_err), 1);
      chk("to_fill0", DW'(fill_count), 0);
      push_frame(8'h20);
`else
      repeat (12) @(negedge clk);
      chk("idle_fill_kept", DW'(fill_count), 4);
      chk("idle_no_err", DW'(frame_err), 0);
      for (int i = 4; i < N; i++) push(8'h20 + 8'(i), i == N - 1);
`endif
      chk("idle_done_valid", DW'(frame_valid), 1);
      chk("idle_done_data", frame_data, frame_of(8'h20));
      @(negedge clk);

      chk("err_pulse_total", DW'(err_pulses), DW'(EXP_ERRS));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time budget");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tree_feature_loader.md
Name: tree_feature_loader

Overview:
- Upstream stage of the printed decision-tree classifier.
- Accepts a byte-serial stream of quantised 8-bit features and assembles them into a full parallel feature vector, feature 0 first.
- Holds the vector stable on its output for the combinational tree, with a valid/ready handshake.
- Double-buffered: a fill buffer collects the next frame while the output buffer is held for the consumer.

Parameters:
- NUM_FEATURES, 18, number of features per frame (2..64).
- FW, 8, bits per feature.
- TIMEOUT_CYCLES, 255, idle cycles inside a partial frame before abort (used only with the optional feature).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_data  input  FW  incoming feature value.
- s_valid  input  1  s_data is valid.
- s_last  input  1  marks the final feature of a frame.
- s_ready  output  1  loader can accept a byte.
- frame_data  output  NUM_FEATURES*FW  feature i at bits [i*FW +: FW].
- frame_valid  output  1  frame_data holds a complete frame.
- frame_ready  input  1  consumer has sampled frame_data.
- frame_err  output  1  one-cycle pulse when a frame is discarded.
- fill_count  output  clog2(NUM_FEATURES+1)  bytes currently in the fill buffer.

Behaviour:
- Reset (asynchronous, immediate): s_ready=0, frame_valid=0, frame_err=0, fill_count=0, frame_data=0, FSM=FILL. s_ready rises on the first clock edge after rst deasserts.
- Input handshake: a byte transfers on a clk edge where s_valid && s_ready. It writes fill slot fill_count, then fill_count increments.
- FSM states:
  - FILL: s_ready=1. On a transfer:
    - if fill_count==NUM_FEATURES-1 and s_last=1, the frame is complete.
    - if s_last=1 earlier than slot NUM_FEATURES-1, the frame is short: frame_err pulses, fill_count resets to 0, stay in FILL.
    - if slot NUM_FEATURES-1 is written with s_last=0, the frame is long: frame_err pulses, fill_count resets to 0, go to DROP.
  - On a complete frame, the fill buffer copies to the output buffer on the same edge if frame_valid==0 or frame_ready==1. Then frame_valid=1, fill_count=0, stay in FILL. Otherwise go to HOLD.
  - HOLD: s_ready=0. Waits for frame_ready while frame_valid=1. On that edge the fill buffer copies to the output buffer, frame_valid stays 1, fill_count=0, go to FILL.
  - DROP: s_ready=1. Bytes are discarded until a byte with s_last=1 transfers, then go to FILL. No further frame_err pulses in DROP.
- Output handshake: frame_valid falls on an edge with frame_ready=1 unless a new frame loads on that same edge. frame_data changes only on a load edge and is never modified while frame_valid=1 and frame_ready=0.
- Latency: from the final byte transfer to frame_valid=1 is 1 cycle when the output buffer is free.
- Throughput: one frame per NUM_FEATURES cycles with no bubbles when frame_ready is held high.
- frame_err is asserted for exactly 1 cycle per discarded frame. A short frame and the next frame's first byte cannot coincide, because one byte transfers per cycle.
- Reset mid-frame: partial data is lost and no frame_err is raised. frame_data is cleared.
- fill_count never exceeds NUM_FEATURES-1 after any edge.

Optional Feature:
- Macro: TREE_LOADER_TIMEOUT_EN.
- With the macro defined: an idle counter runs in FILL while fill_count!=0 and no transfer occurs, and clears on every transfer. When it reaches TIMEOUT_CYCLES, the partial frame is aborted: frame_err pulses, fill_count=0. The counter resets on rst.
- Without the macro: no counter is built, and partial frames wait indefinitely. TIMEOUT_CYCLES is unused.

Test Plan:
- Reset, then 18 bytes 0x00..0x11 with s_last on the 18th, frame_ready=1 → frame_valid=1 one cycle after the last byte; frame_data[7:0]=0x00, [143:136]=0x11; frame_err never set.
- Two back-to-back frames, frame_ready=0 until both arrive → after frame 2 completes s_ready=0 and FSM=HOLD; frame 1 is held unchanged. After a frame_ready pulse, frame_data shows frame 2 on the next edge and s_ready=1.
- Short frame: s_last on byte 5 → single-cycle frame_err, fill_count=0. The next 18-byte frame is delivered correctly.
- Long frame: 20 bytes with s_last on byte 20 → frame_err pulse at byte 18, bytes 19-20 dropped, no frame_valid. The next frame loads normally.
- rst asserted asynchronously after 9 bytes → outputs go to 0 immediately without a clk edge. A full frame after release is delivered.
- TREE_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=10: 4 bytes then 10 idle cycles → frame_err pulse, fill_count=0. Without the macro, fill_count stays 4.
